// File: rtl/instruction_fetch_decode_unit_if.sv
// Signal bundle between the fetch/pre-decode stage, instruction memory and execute.
// Handshakes: imem_req/imem_ready completes a fetch in any cycle both are high, with
// imem_addr held stable while imem_req waits for imem_ready. out_valid/out_ready
// transfers an instruction in any cycle both are high, with instr held stable while
// out_valid waits for out_ready.
interface instruction_fetch_decode_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [23:0] imm_field;
  logic [1:0]  imm_src;
  logic [31:0] pc_plus8;
  logic        illegal;

  modport master (
    output imem_req, imem_addr, out_valid, instr, imm_field, imm_src, pc_plus8, illegal,
    input  imem_ready, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, instr, imm_field, imm_src, pc_plus8, illegal,
    output imem_ready, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_decode_unit.sv
// Fetch and pre-decode stage: holds the PC, fetches one instruction at a time, latches it
// into the instruction register and presents immediate field/select to the extension unit.
module instruction_fetch_decode_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  instruction_fetch_decode_unit_if.master       bus,
  output logic [1:0]                            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    VALID   = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus8_q;
  logic [31:0] redir_pc;

  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH: begin
        if (bus.redirect && !bus.imem_ready) begin
          state_d = DISCARD;
        end else if (!bus.redirect && bus.imem_ready) begin
          state_d = VALID;
        end
      end
      DISCARD: if (bus.imem_ready) state_d = FETCH;
      VALID:   if (bus.redirect || bus.out_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // A redirect during an unanswered fetch parks its target until the old response drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      target_q   <= 32'h0;
      instr_q    <= 32'h0;
      pc_plus8_q <= 32'h0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.redirect) begin
            if (bus.imem_ready) begin
              pc_q <= redir_pc;
            end else begin
              target_q <= redir_pc;
            end
          end else if (bus.imem_ready) begin
            instr_q    <= bus.imem_rdata;
            pc_plus8_q <= pc_q + 32'd8;
            pc_q       <= pc_q + 32'd4;
          end
        end
        DISCARD: begin
          if (bus.imem_ready) begin
            pc_q <= bus.redirect ? redir_pc : target_q;
          end else if (bus.redirect) begin
            target_q <= redir_pc;
          end
        end
        VALID: begin
          if (bus.redirect) begin
            pc_q <= redir_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (state_q == VALID) && !bus.redirect;
  assign bus.instr     = instr_q;
  assign bus.imm_field = instr_q[23:0];
  assign bus.imm_src   = instr_q[27:26];
  assign bus.illegal   = (instr_q[27:26] == 2'b11);
  assign bus.pc_plus8  = pc_plus8_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instruction_fetch_decode_unit.sv
// Directed, table-driven bench for instruction_fetch_decode_unit: one record per clock cycle,
// plus a hand-written reset-in-DISCARD sequence.
module tb_instruction_fetch_decode_unit;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;

  instruction_fetch_decode_unit_if bus ();

  instruction_fetch_decode_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] rdpc;
    logic        ordy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc8;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  function automatic void add(input logic rdy, input logic [31:0] rdata, input logic rd,
                              input logic [31:0] rdpc, input logic ordy, input logic ereq,
                              input logic [31:0] eaddr, input logic evalid,
                              input logic [31:0] einstr, input logic [31:0] epc8);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.rd = rd; v.rdpc = rdpc; v.ordy = ordy;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr; v.epc8 = epc8;
    vecs.push_back(v);
  endfunction

  function automatic void chk(input string name, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endfunction

  // scoreboard: compare every output against the record's expectations
  task automatic check_outputs(input int idx, input logic ereq, input logic [31:0] eaddr,
                               input logic evalid, input logic [31:0] einstr,
                               input logic [31:0] epc8, input logic eill);
    logic [31:0] ei;
    ei = einstr;
    n_vec++;
    chk("imem_req",  idx, {31'b0, bus.imem_req},  {31'b0, ereq});
    chk("imem_addr", idx, bus.imem_addr,          eaddr);
    chk("out_valid", idx, {31'b0, bus.out_valid}, {31'b0, evalid});
    chk("instr",     idx, bus.instr,              ei);
    chk("imm_field", idx, {8'b0, bus.imm_field},  {8'b0, ei[23:0]});
    chk("imm_src",   idx, {30'b0, bus.imm_src},   {30'b0, ei[27:26]});
    chk("pc_plus8",  idx, bus.pc_plus8,           epc8);
    chk("illegal",   idx, {31'b0, bus.illegal},   {31'b0, eill});
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic rd,
                       input logic [31:0] rdpc, input logic ordy);
    bus.imem_ready  = rdy;
    bus.imem_rdata  = rdata;
    bus.redirect    = rd;
    bus.redirect_pc = rdpc;
    bus.out_ready   = ordy;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    //  rdy rdata          rd rdpc           ordy | req addr          valid instr          pc8
    add(0, 32'h0,          0, 32'h0,         1,     0, 32'h0,         0, 32'h0,          32'h0);  // 0 IDLE
    add(1, 32'hE3A0_1005,  0, 32'h0,         1,     1, 32'h0,         0, 32'h0,          32'h0);  // 1
    add(0, 32'h0,          0, 32'h0,         1,     0, 32'h4,         1, 32'hE3A0_1005,  32'h8);  // 2
    add(1, 32'hE591_2004,  0, 32'h0,         1,     1, 32'h4,         0, 32'hE3A0_1005,  32'h8);  // 3
    add(0, 32'h0,          0, 32'h0,         1,     0, 32'h8,         1, 32'hE591_2004,  32'hC);  // 4
    add(1, 32'hEA00_0003,  0, 32'h0,         1,     1, 32'h8,         0, 32'hE591_2004,  32'hC);  // 5
    for (int k = 0; k < 5; k++)                                                                   // 6..10 stall
      add(0, 32'h0,        0, 32'h0,         0,     0, 32'hC,         1, 32'hEA00_0003,  32'h10);
    add(0, 32'h0,          0, 32'h0,         1,     0, 32'hC,         1, 32'hEA00_0003,  32'h10); // 11 release
    add(0, 32'h0,          0, 32'h0,         1,     1, 32'hC,         0, 32'hEA00_0003,  32'h10); // 12
    add(1, 32'hE3A0_1005,  0, 32'h0,         1,     1, 32'hC,         0, 32'hEA00_0003,  32'h10); // 13
    add(0, 32'h0,          1, 32'h0000_0103, 1,     0, 32'h10,        0, 32'hE3A0_1005,  32'h14); // 14 redirect in VALID
    add(0, 32'h0,          1, 32'h0000_0200, 1,     1, 32'h100,       0, 32'hE3A0_1005,  32'h14); // 15 redirect, no ready
    add(0, 32'h0,          0, 32'h0,         1,     1, 32'h100,       0, 32'hE3A0_1005,  32'h14); // 16 DISCARD
    add(0, 32'h0,          0, 32'h0,         1,     1, 32'h100,       0, 32'hE3A0_1005,  32'h14); // 17
    add(1, 32'hEC00_0000,  0, 32'h0,         1,     1, 32'h100,       0, 32'hE3A0_1005,  32'h14); // 18 drained
    add(0, 32'h0,          1, 32'h0000_0250, 1,     1, 32'h200,       0, 32'hE3A0_1005,  32'h14); // 19
    add(0, 32'h0,          1, 32'h0000_0300, 1,     1, 32'h200,       0, 32'hE3A0_1005,  32'h14); // 20 latest wins
    add(1, 32'hE591_2004,  0, 32'h0,         1,     1, 32'h200,       0, 32'hE3A0_1005,  32'h14); // 21
    add(1, 32'hEC00_0000,  0, 32'h0,         1,     1, 32'h300,       0, 32'hE3A0_1005,  32'h14); // 22
    add(0, 32'h0,          0, 32'h0,         1,     0, 32'h304,       1, 32'hEC00_0000,  32'h308);// 23 illegal
    add(1, 32'hE591_2004,  1, 32'hFFFF_FFFE, 1,     1, 32'h304,       0, 32'hEC00_0000,  32'h308);// 24 redirect+ready
    add(1, 32'hE3A0_1005,  0, 32'h0,         1,     1, 32'hFFFF_FFFC, 0, 32'hEC00_0000,  32'h308);// 25
    add(0, 32'h0,          0, 32'h0,         1,     0, 32'h0,         1, 32'hE3A0_1005,  32'h4);  // 26 wrap
    add(0, 32'h0,          1, 32'h0000_0400, 1,     1, 32'h0,         0, 32'hE3A0_1005,  32'h4);  // 27
    add(1, 32'hEA00_0003,  1, 32'h0000_0500, 1,     1, 32'h0,         0, 32'hE3A0_1005,  32'h4);  // 28 same-cycle
    add(0, 32'h0,          0, 32'h0,         1,     1, 32'h500,       0, 32'hE3A0_1005,  32'h4);  // 29
    add(0, 32'h0,          1, 32'h0000_0600, 1,     1, 32'h500,       0, 32'hE3A0_1005,  32'h4);  // 30
    add(0, 32'h0,          0, 32'h0,         1,     1, 32'h500,       0, 32'hE3A0_1005,  32'h4);  // 31 DISCARD

    reset_n = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // each record: drive after the edge, sample at the falling edge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rdy, vecs[i].rdata, vecs[i].rd, vecs[i].rdpc, vecs[i].ordy);
      @(negedge clk);
      check_outputs(i, vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].einstr,
                    vecs[i].epc8, (vecs[i].einstr[27:26] == 2'b11));
      @(posedge clk);
      #1;
    end

    // reset asserted while in DISCARD: outputs return at once, before any clock edge
    drive(0, 32'h0, 0, 32'h0, 1);
    chk("dbg_state_discard", 100, {30'b0, dbg_state}, 32'd2);
    reset_n = 1'b0;
    #1;
    check_outputs(101, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    check_outputs(102, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs(103, 0, 32'h0, 0, 32'h0, 32'h0, 0);   // IDLE cycle
    @(negedge clk);
    check_outputs(104, 1, 32'h0, 0, 32'h0, 32'h0, 0);   // first fetch at RESET_PC
    drive(1, 32'hE591_2004, 0, 32'h0, 1);
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0, 1);
    check_outputs(105, 0, 32'h4, 1, 32'hE591_2004, 32'h8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_decode_unit.md
# instruction_fetch_decode_unit

Fetch and pre-decode stage that sits directly upstream of the immediate extension unit. It holds the PC, fetches 32-bit instructions over a req/ready instruction-memory interface, and latches each one into an instruction register. From that register it drives the 24-bit immediate field and the 2-bit extension select consumed by the extension unit, through a valid/ready handshake toward execute. It also accepts branch redirects from execute and discards any fetch still in flight when a redirect arrives.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; low 2 bits must be 0.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; word aligned.
- imem_ready  input  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction.
- redirect  input  1  branch taken; flush and refetch.
- redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
- out_valid  output  1  instruction register holds a deliverable instruction.
- out_ready  input  1  downstream accepts.
- instr  output  32  instruction register.
- imm_field  output  24  instr[23:0]; drives extension input a.
- imm_src  output  2  instr[27:26]; drives extension select s.
- pc_plus8  output  32  fetch address of instr + 8.
- illegal  output  1  instr[27:26] == 2'b11.

## Operation
- States: IDLE, FETCH, DISCARD, VALID. Reset state is IDLE. IDLE moves to FETCH unconditionally after one cycle.
- imem_req = 1 in FETCH and DISCARD, otherwise 0.
- While imem_req is 1, imem_addr = pc and is held stable until imem_ready.
- FETCH, imem_ready=1, redirect=0:
  - instr <= imem_rdata.
  - pc_plus8 <= pc+8.
  - pc <= pc+4.
  - Next state VALID.
- FETCH, redirect=1 (with or without imem_ready):
  - If imem_ready=1: discard rdata, pc <= redirect_pc, stay in FETCH.
  - If imem_ready=0: target register <= redirect_pc, go to DISCARD. The outstanding request stays at the old address.
- DISCARD:
  - On imem_ready: drop rdata, pc <= target, go to FETCH.
  - A redirect while in DISCARD overwrites target; the latest redirect wins.
  - A redirect in the same cycle as imem_ready: pc <= the new redirect_pc.
- VALID:
  - out_valid = (state==VALID) && !redirect. Redirect has priority, so no transfer occurs in the cycle redirect is high.
  - If out_ready=1 and redirect=0: transfer; next state FETCH.
  - If redirect=1: pc <= redirect_pc, next state FETCH, and the held instruction is lost.
  - Otherwise hold instr and all outputs stable.
- Decode: imm_src = instr[27:26] (00 imm8, 01 imm12, 10 branch imm24). Value 11 sets illegal=1; such an instruction is still delivered with imm_src=11.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0, with no error flag.
- Reset values: imem_req 0, imem_addr RESET_PC, out_valid 0, instr 0, imm_field 0, imm_src 00, pc_plus8 0, illegal 0; internal pc = RESET_PC, target = 0.
- Reset mid-operation: all state returns immediately to IDLE and reset values. Any outstanding memory request is abandoned, and the memory must tolerate imem_req dropping.

## Timing
- First imem_req is asserted in the 2nd cycle after reset_n deasserts (the IDLE cycle comes first).
- imem_ready in cycle N produces out_valid=1 in cycle N+1.
- Transfer in cycle M produces the next imem_req in cycle M+1.
- Peak throughput is 1 instruction per 2 cycles, with zero-wait memory and out_ready held at 1.
- Redirect in FETCH with no ready: the next useful fetch starts the cycle after the pending response arrives.
- imm_field, imm_src, and illegal are combinational from the instr register; there is no extra latency.
- out_valid has a combinational path from redirect; all other outputs are registered state or decode of registered state.

## Test plan
- Reset, then zero-wait memory with out_ready=1 returning E3A0_1005, E591_2004, EA00_0003 -> addresses 0, 4, 8; imm_src 00, 01, 10; pc_plus8 8, C, 10; out_valid every other cycle.
- Backpressure: out_ready=0 for 5 cycles in VALID -> instr, imm_field, and out_valid stay stable, imem_req=0; transfer on release, next fetch at pc+4.
- Redirect in VALID with out_ready=1, redirect_pc=0x0000_0103 -> no transfer that cycle; next imem_addr = 0x0000_0100.
- Redirect while imem_ready=0 (target 0x200), response 3 cycles later -> response discarded, out_valid stays 0, next imem_addr = 0x200. Repeat with a second redirect to 0x300 while in DISCARD -> next fetch at 0x300.
- Fetch of 0xEC00_0000 -> illegal=1, imm_src=11, delivered normally. PC at 0xFFFF_FFFC -> next fetch at 0.
- Assert reset_n=0 mid-DISCARD -> all outputs immediately at reset values; first fetch after release at RESET_PC.
